// File: rtl/inst_ram_loader_pkg.sv
// Shared types and constants for the instruction RAM loader.
// Bus widths, fetch constants and loader state encodings.
package inst_ram_loader_pkg;

    localparam int InstBusW = 32;
    localparam int InstAddrBusW = 32;

    typedef logic [InstBusW-1:0] instBus_t;
    typedef logic [InstAddrBusW-1:0] instAddrBus_t;

    localparam instBus_t ZeroWord = '0;
    localparam logic ChipEnable = 1'b1;

    typedef enum logic [1:0] {
        LdIdle = 2'd0,
        LdLoad = 2'd1,
        LdDone = 2'd2
    } ldState_t;

endpackage

// File: rtl/inst_ram_loader_inst_mem_array.sv
// Instruction word storage: combinational read, synchronous write.
// Contents are never reset.
module inst_mem_array
    import inst_ram_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  instBus_t          wdata,
    input  logic [ADDR_W-1:0] raddr,
    output instBus_t          rdata
);

    instBus_t mem [2**ADDR_W];

    // Write port; a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_ram_loader.sv
// Fetch responder plus byte-serial program loader.
// Holds the CPU in reset while a program is written.
module inst_ram_loader
    import inst_ram_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce,
    input  instAddrBus_t      rom_addr,
    output instBus_t          rom_inst,
    input  logic              ld_start,
    input  logic [ADDR_W:0]   ld_len,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              cpu_rst
);

    localparam logic [ADDR_W:0] OneWord = 1;

    ldState_t state;
    ldState_t nextState;

    logic [ADDR_W:0] lenQ;
    logic [ADDR_W:0] wordCnt;
    logic [1:0]      byteCnt;
    logic [23:0]     acc;
    logic            byteFire;
    logic            wordFire;
    logic            lastWord;
    instBus_t        rdata;
    logic            unusedAddrBits;

    assign byteFire = ld_valid && ld_ready;
    assign wordFire = byteFire && (byteCnt == 2'd3);
    assign lastWord = (wordCnt + OneWord) == lenQ;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LdIdle;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; a new start is ignored mid-load.
    always_comb begin
        nextState = state;
        unique case (state)
            LdIdle: begin
                if (ld_start) begin
                    nextState = (ld_len == '0) ? LdDone : LdLoad;
                end
            end
            LdLoad: begin
                if (wordFire && lastWord) begin
                    nextState = LdDone;
                end
            end
            LdDone:  nextState = LdIdle;
            default: nextState = LdIdle;
        endcase
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        ld_ready = (state == LdLoad);
        ld_busy  = (state != LdIdle);
        ld_done  = (state == LdDone);
    end

    // Byte assembler and word pointer; a partial word dies on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lenQ    <= '0;
            wordCnt <= '0;
            byteCnt <= '0;
            acc     <= '0;
        end else if (state == LdIdle && ld_start) begin
            lenQ    <= ld_len;
            wordCnt <= '0;
            byteCnt <= '0;
            acc     <= '0;
        end else if (byteFire) begin
            byteCnt <= byteCnt + 2'd1;
            acc     <= {acc[15:0], ld_data};
            if (wordFire) begin
                wordCnt <= wordCnt + OneWord;
            end
        end
    end

    // CPU reset follows the next state so it leaves with DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rst <= 1'b1;
        end else begin
            cpu_rst <= (nextState != LdIdle);
        end
    end

    inst_mem_array #(
        .ADDR_W(ADDR_W)
    ) uMem (
        .clk  (clk),
        .we   (wordFire),
        .waddr(wordCnt[ADDR_W-1:0]),
        .wdata({acc, ld_data}),
        .raddr(rom_addr[ADDR_W+1:2]),
        .rdata(rdata)
    );

    assign unusedAddrBits = ^{rom_addr[31:ADDR_W+2], rom_addr[1:0]};

    assign rom_inst = (rom_ce == ChipEnable && !ld_busy) ? rdata : ZeroWord;

endmodule

// File: tb/tb_inst_ram_loader.sv
// Directed bench for inst_ram_loader.
// Two instances share stimulus; the small one exercises wrap.
module tb_inst_ram_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        romCe = 1'b0;
    logic [31:0] romAddr = '0;
    logic        ldStart = 1'b0;
    logic [10:0] ldLen = '0;
    logic        ldValid = 1'b0;
    logic [7:0]  ldData = '0;

    logic [31:0] romInstA, romInstB;
    logic ldReadyA, ldBusyA, ldDoneA, cpuRstA;
    logic ldReadyB, ldBusyB, ldDoneB, cpuRstB;

    int checks = 0;
    int errors = 0;

    logic [31:0] words[$];
    int  doneCyc;
    bit  rstDropped;
    bit  instLeak;

    always #5 clk = ~clk;

    inst_ram_loader #(.ADDR_W(10)) dutA (
        .clk(clk), .rst(rst), .rom_ce(romCe), .rom_addr(romAddr),
        .rom_inst(romInstA), .ld_start(ldStart), .ld_len(ldLen),
        .ld_valid(ldValid), .ld_data(ldData), .ld_ready(ldReadyA),
        .ld_busy(ldBusyA), .ld_done(ldDoneA), .cpu_rst(cpuRstA)
    );

    inst_ram_loader #(.ADDR_W(2)) dutB (
        .clk(clk), .rst(rst), .rom_ce(romCe), .rom_addr(romAddr),
        .rom_inst(romInstB), .ld_start(ldStart), .ld_len(ldLen[2:0]),
        .ld_valid(ldValid), .ld_data(ldData), .ld_ready(ldReadyB),
        .ld_busy(ldBusyB), .ld_done(ldDoneB), .cpu_rst(cpuRstB)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp, input bit useB);
        romCe = 1'b1;
        romAddr = addr;
        #1;
        chk(tag, useB ? romInstB : romInstA, exp);
    endtask

    // Streams the words in the queue; returns cycles from start to done.
    task automatic runLoad(input int nWords, input bit toggle,
                           input bit injectStart);
        int cyc;
        int idx;
        int k;
        int total;
        total = nWords * 4;
        rstDropped = 1'b0;
        instLeak = 1'b0;
        romCe = 1'b1;
        romAddr = '0;
        ldLen = 11'(nWords);
        ldStart = 1'b1;
        tick();
        ldStart = 1'b0;
        cyc = 1;
        idx = 0;
        k = 0;
        while (ldDoneA !== 1'b1 && cyc < 200) begin
            if (cpuRstA !== 1'b1) rstDropped = 1'b1;
            if (romInstA !== 32'h0) instLeak = 1'b1;
            ldValid = (!toggle || (k % 2 == 0)) && (idx < total);
            if (idx < total)
                ldData = 8'(words[idx / 4] >> (24 - 8 * (idx % 4)));
            ldStart = injectStart && (k == 2);
            if (injectStart && k == 2) ldLen = 11'd7;
            tick();
            if (ldValid) idx++;
            ldStart = 1'b0;
            k++;
            cyc++;
        end
        ldValid = 1'b0;
        doneCyc = (ldDoneA === 1'b1) ? cyc : -1;
    endtask

    initial begin
        // Reset behaviour.
        tick();
        tick();
        chk("rst_cpu_rst", 32'(cpuRstA), 32'd1);
        chk("rst_ready", 32'(ldReadyA), 32'd0);
        chk("rst_busy", 32'(ldBusyA), 32'd0);
        chk("rst_done", 32'(ldDoneA), 32'd0);
        chk("rst_inst_ce0", romInstA, 32'h0);
        rst = 1'b0;
        #1;
        chk("cpu_rst_hold", 32'(cpuRstA), 32'd1);
        tick();
        chk("cpu_rst_fall", 32'(cpuRstA), 32'd0);
        chk("idle_busy", 32'(ldBusyA), 32'd0);

        // Two-word load, valid held high, stray start mid-load.
        words = '{32'h34010010, 32'h00000000};
        runLoad(2, 1'b0, 1'b1);
        chk("load2_done_cyc", 32'(doneCyc), 32'd9);
        chk("load2_cpu_rst_done", 32'(cpuRstA), 32'd1);
        chk("load2_busy_done", 32'(ldBusyA), 32'd1);
        chk("load2_cpu_rst_run", 32'(rstDropped), 32'd0);
        chk("load2_inst_nop", 32'(instLeak), 32'd0);
        tick();
        chk("load2_done_clr", 32'(ldDoneA), 32'd0);
        chk("load2_cpu_rst_clr", 32'(cpuRstA), 32'd0);
        fetch("load2_mem0", 32'h0, 32'h34010010, 1'b0);
        fetch("load2_mem1", 32'h4, 32'h0, 1'b0);

        // One-word load to change contents.
        words = '{32'hDEADBEEF};
        runLoad(1, 1'b0, 1'b0);
        chk("load1_done_cyc", 32'(doneCyc), 32'd5);
        tick();
        fetch("load1_mem0", 32'h0, 32'hDEADBEEF, 1'b0);
        fetch("load1_mem1", 32'h4, 32'h0, 1'b0);

        // Same two-word load with valid toggling.
        words = '{32'h34010010, 32'h00000000};
        runLoad(2, 1'b1, 1'b0);
        chk("tog_done_cyc", 32'(doneCyc), 32'd16);
        chk("tog_cpu_rst_run", 32'(rstDropped), 32'd0);
        tick();
        fetch("tog_mem0", 32'h0, 32'h34010010, 1'b0);
        fetch("tog_mem1", 32'h4, 32'h0, 1'b0);

        // Reset after 6 bytes of a 3-word load.
        romCe = 1'b1;
        romAddr = '0;
        ldLen = 11'd3;
        ldStart = 1'b1;
        tick();
        ldStart = 1'b0;
        words = '{32'hAABBCCDD, 32'h11223344, 32'h55667788};
        for (int i = 0; i < 6; i++) begin
            ldValid = 1'b1;
            ldData = 8'(words[i / 4] >> (24 - 8 * (i % 4)));
            tick();
        end
        chk("abort_busy_pre", 32'(ldBusyA), 32'd1);
        ldValid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(ldBusyA), 32'd0);
        chk("abort_done", 32'(ldDoneA), 32'd0);
        chk("abort_cpu_rst", 32'(cpuRstA), 32'd1);
        tick();
        chk("abort_cpu_rst_fall", 32'(cpuRstA), 32'd0);
        chk("abort_done2", 32'(ldDoneA), 32'd0);
        fetch("abort_mem0", 32'h0, 32'hAABBCCDD, 1'b0);
        fetch("abort_mem1", 32'h4, 32'h0, 1'b0);

        // Zero-length load.
        ldLen = 11'd0;
        ldStart = 1'b1;
        tick();
        ldStart = 1'b0;
        chk("zero_busy", 32'(ldBusyA), 32'd1);
        chk("zero_done", 32'(ldDoneA), 32'd1);
        chk("zero_cpu_rst", 32'(cpuRstA), 32'd1);
        tick();
        chk("zero_busy_clr", 32'(ldBusyA), 32'd0);
        chk("zero_done_clr", 32'(ldDoneA), 32'd0);
        chk("zero_cpu_rst_clr", 32'(cpuRstA), 32'd0);
        fetch("zero_mem0", 32'h0, 32'hAABBCCDD, 1'b0);

        // Five words into the 4-deep instance wrap onto word 0.
        words = '{32'h11111111, 32'h22222222, 32'h33333333,
                  32'h44444444, 32'h55555555};
        runLoad(5, 1'b0, 1'b0);
        chk("wrap_done_cyc", 32'(doneCyc), 32'd21);
        chk("wrap_done_b", 32'(ldDoneB), 32'd1);
        tick();
        fetch("wrap_b_mem0", 32'h0, 32'h55555555, 1'b1);
        fetch("wrap_b_addr10", 32'h10, 32'h55555555, 1'b1);
        fetch("wrap_b_mem1", 32'h4, 32'h22222222, 1'b1);
        fetch("wrap_b_mem3", 32'hC, 32'h44444444, 1'b1);
        fetch("wrap_a_mem0", 32'h0, 32'h11111111, 1'b0);
        fetch("wrap_a_mem4", 32'h10, 32'h55555555, 1'b0);
        romCe = 1'b0;
        #1;
        chk("ce_off_nop", romInstA, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_ram_loader.md
# inst_ram_loader

Instruction-memory responder on the CPU's fetch interface. It answers `rom_ce`/`rom_addr` with `rom_inst` from an internal word array. A byte-serial loader fills that array at run time and holds the CPU in reset while a program is being written. It sits beside the CPU top: its `rom_*` ports connect to the CPU's `rom_*` ports, and its `cpu_rst` drives the CPU's `rst`.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width; array depth is 2^ADDR_W 32-bit words.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rom_ce`  in  1  fetch enable from the CPU.
- `rom_addr`  in  32  byte address from the CPU (`InstAddrBus`).
- `rom_inst`  out  32  fetched instruction word (`InstBus`).
- `ld_start`  in  1  single-cycle pulse that begins a load.
- `ld_len`  in  ADDR_W+1  number of words to load; sampled with `ld_start`.
- `ld_valid`  in  1  byte-stream valid.
- `ld_data`  in  8  byte-stream data; most significant byte of each word first.
- `ld_ready`  out  1  loader accepts a byte.
- `ld_busy`  out  1  load in progress.
- `ld_done`  out  1  one-cycle pulse when a load completes.
- `cpu_rst`  out  1  registered reset to the CPU.

## Operation
- Fetch (combinational):
  - `rom_inst = mem[rom_addr[ADDR_W+1:2]]` when `rom_ce`=1, `ld_busy`=0.
  - `rom_inst` = 0 (NOP) when `rom_ce`=0 or `ld_busy`=1.
  - `rom_addr[1:0]` and bits above ADDR_W+1 are ignored, so addresses wrap modulo the array depth.
- The FSM has three states: IDLE, LOAD, DONE. Reset puts it in IDLE.
- IDLE:
  - `ld_start`=1 with `ld_len`≠0: latch `ld_len`, clear the word pointer and byte count, go to LOAD.
  - `ld_start`=1 with `ld_len`=0: go to DONE without writing anything.
- LOAD:
  - `ld_ready`=1; a byte is accepted on any cycle where `ld_valid`&&`ld_ready`.
  - Bytes 0–2 of a word shift into a 24-bit accumulator.
  - On byte 3, write `mem[ptr] <= {acc, ld_data}` on the same edge and increment `ptr`.
  - If that byte completes the word `ptr == len-1`, go to DONE.
  - `ld_start` is ignored in this state.
  - `ptr` wraps modulo the depth when `len` > depth; later words overwrite earlier ones.
- DONE: `ld_done`=1 for exactly one cycle, then return to IDLE.
- `ld_busy` = (state ≠ IDLE).
- `cpu_rst`:
  - Registered; set to 1 by `rst`.
  - Otherwise the next value is 1 iff the next state is LOAD or DONE.
- Reset values: state IDLE, `ptr` = 0, byte count 0, accumulator 0, `ld_ready` 0, `ld_busy` 0, `ld_done` 0, `cpu_rst` 1, `rom_inst` as the combinational rule above. The memory array is not reset.
- `rst` mid-load: the load aborts and a partial word is discarded. Words already written are retained. The FSM returns to IDLE with no `ld_done` pulse.

## Timing
- Fetch latency is 0 cycles (combinational). The CPU's `if_id` register captures the word on the next edge.
- A write and a fetch to the same word in the same cycle: the fetch returns the old value (it is forced to 0 anyway while busy).
- An N-word load takes ≥4N LOAD cycles (exactly 4N with `ld_valid` held high) plus one DONE cycle.
- `cpu_rst` rises on the edge that enters LOAD/DONE and falls on the edge leaving DONE. The CPU therefore starts fetching from address 0 one cycle after `ld_done`.
- After external `rst` deasserts with no load pending, `cpu_rst` falls one cycle later.
- `ld_len`=0 load: `ld_busy`, `ld_done` and `cpu_rst` are each high for exactly one cycle.

## Structure
- Shared `defines.v` additions:
  - the loader state encodings `LdIdle`, `LdLoad`, `LdDone`;
  - existing `InstBus`, `InstAddrBus`, `ZeroWord`, `ChipEnable`.
- One sub-module, `inst_mem_array`: 2^ADDR_W × 32 storage with a combinational read port and a synchronous write port (`we`, `waddr`, `wdata`).
- The FSM, byte assembler and `cpu_rst` register live in `inst_ram_loader`.

## Test plan
- Reset release, no load: `cpu_rst`=1 during reset and 0 one cycle after; `ld_ready`/`ld_busy`/`ld_done` = 0.
- Load 2 words from bytes 34 01 00 10 | 00 00 00 00, `ld_valid` held high:
  - `mem[0]`=0x34010010, `mem[1]`=0;
  - `ld_done` pulses 9 cycles after `ld_start`;
  - fetch `rom_addr`=0x4 with `rom_ce`=1 returns 0.
- Same load with `ld_valid` toggling every other cycle: identical memory contents; `ld_done` is delayed accordingly; `cpu_rst` stays high throughout.
- During LOAD, `rom_ce`=1, `rom_addr`=0 → `rom_inst`=0. A second `ld_start` is ignored (`ld_len` unchanged, load completes normally).
- `rst` after 6 bytes of a 3-word load:
  - `mem[0]` holds word 0 and `mem[1]` is unchanged;
  - FSM in IDLE and no `ld_done`;
  - a subsequent `ld_len`=0 start gives one-cycle `ld_busy`/`ld_done`.
- With ADDR_W=2, load 5 words 0x11111111..0x55555555:
  - `mem[0]`=0x55555555;
  - fetch at `rom_addr`=0x10 returns 0x55555555 (address wrap).
